// File: rtl/bp_lce_stall_ctrl.sv
// rtl/bp_lce_stall_ctrl.sv - LCE busy/stall controller: per-channel starvation timers, hold FSM, credit counter
// Optional statistics outputs are enabled by defining BP_LCE_STALL_CTRL_STATS_EN.
module bp_lce_stall_ctrl #(
    parameter int channels_p          = 3,
    parameter int timeout_max_limit_p = 4,
    parameter int hold_cycles_p       = 2,
    parameter int credits_p           = 4,
    parameter int stat_width_p        = 32,
    localparam int credit_width_lp    = $clog2(credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [channels_p-1:0]      mem_pkt_v_i,
    input  logic [channels_p-1:0]      mem_pkt_yumi_i,
    input  logic                       cmd_ready_i,
    input  logic                       req_ready_i,
    input  logic                       credit_consume_i,
    input  logic                       credit_return_i,
    output logic [credit_width_lp-1:0] credit_count_o,
    output logic                       credits_full_o,
    output logic                       credits_empty_o,
    output logic                       timeout_o,
    output logic [channels_p-1:0]      timeout_chan_o,
`ifdef BP_LCE_STALL_CTRL_STATS_EN
    output logic [stat_width_p-1:0]    timeout_events_o,
    output logic [stat_width_p-1:0]    busy_cycles_o,
`endif
    output logic                       cache_req_busy_o
);

    localparam int cnt_width_lp  = $clog2(timeout_max_limit_p + 1);
    localparam int hold_width_lp = (hold_cycles_p > 0) ? $clog2(hold_cycles_p + 1) : 1;
    localparam logic [cnt_width_lp-1:0]    cnt_max_lp    = cnt_width_lp'(timeout_max_limit_p);
    localparam logic [hold_width_lp-1:0]   hold_load_lp  = hold_width_lp'(hold_cycles_p);
    localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(credits_p);

    typedef enum logic [1:0] {e_run, e_force, e_drain} state_e;

    state_e                   state;
    logic [hold_width_lp-1:0] hold_cnt;
    logic [cnt_width_lp-1:0]  cnt [channels_p];
    logic [channels_p-1:0]    blk;
    logic [channels_p-1:0]    sat;
    logic [channels_p-1:0]    sat_low;
    logic                     any_sat;

    assign blk = mem_pkt_v_i & ~mem_pkt_yumi_i;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < channels_p; i++) begin
            if (reset_i || !blk[i])
                cnt[i] <= '0;
            else if (cnt[i] != cnt_max_lp)
                cnt[i] <= cnt[i] + cnt_width_lp'(1);
        end
    end

    // Lowest-index saturated channel wins when several starve together.
    always_comb begin
        sat     = '0;
        sat_low = '0;
        for (int i = 0; i < channels_p; i++)
            sat[i] = (cnt[i] == cnt_max_lp);
        for (int i = channels_p - 1; i >= 0; i--) begin
            if (sat[i]) begin
                sat_low    = '0;
                sat_low[i] = 1'b1;
            end
        end
    end

    assign any_sat = |sat;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= e_run;
            hold_cnt       <= '0;
            timeout_chan_o <= '0;
        end else begin
            case (state)
                e_run: begin
                    if (any_sat) begin
                        timeout_chan_o <= sat_low;
                        state          <= e_force;
                    end
                end
                e_force: begin
                    if ((blk & timeout_chan_o) == '0) begin
                        if (hold_cycles_p == 0) begin
                            state          <= e_run;
                            timeout_chan_o <= '0;
                        end else begin
                            state    <= e_drain;
                            hold_cnt <= hold_load_lp;
                        end
                    end
                end
                e_drain: begin
                    if (any_sat) begin
                        timeout_chan_o <= sat_low;
                        state          <= e_force;
                    end else if (hold_cnt == hold_width_lp'(1)) begin
                        state          <= e_run;
                        timeout_chan_o <= '0;
                        hold_cnt       <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - hold_width_lp'(1);
                    end
                end
                default: begin
                    state          <= e_run;
                    timeout_chan_o <= '0;
                end
            endcase
        end
    end

    assign timeout_o        = (state != e_run) | any_sat;
    assign credits_full_o   = (credit_count_o == credit_max_lp);
    assign credits_empty_o  = (credit_count_o == '0);
    assign cache_req_busy_o = reset_i | credits_full_o | timeout_o | ~cmd_ready_i | ~req_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credit_count_o <= '0;
        end else begin
            case ({credit_consume_i, credit_return_i})
                2'b10:   if (!credits_full_o)  credit_count_o <= credit_count_o + credit_width_lp'(1);
                2'b01:   if (!credits_empty_o) credit_count_o <= credit_count_o - credit_width_lp'(1);
                default: credit_count_o <= credit_count_o;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (credit_consume_i && !credit_return_i && credits_full_o)
                $error("bp_lce_stall_ctrl: credit consume while full");
            if (credit_return_i && !credit_consume_i && credits_empty_o)
                $error("bp_lce_stall_ctrl: credit return while empty");
        end
    end
`endif

`ifdef BP_LCE_STALL_CTRL_STATS_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timeout_events_o <= '0;
            busy_cycles_o    <= '0;
        end else begin
            if (state == e_run && any_sat)
                timeout_events_o <= timeout_events_o + stat_width_p'(1);
            if (cache_req_busy_o)
                busy_cycles_o <= busy_cycles_o + stat_width_p'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bp_lce_stall_ctrl.sv
// tb/tb_bp_lce_stall_ctrl.sv - directed and randomized bench for bp_lce_stall_ctrl against a cycle model
module tb_bp_lce_stall_ctrl;

    localparam int C  = 3;
    localparam int L  = 4;
    localparam int H  = 2;
    localparam int CP = 2;
    localparam int CW = $clog2(CP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [C-1:0]  v, y;
    logic          cmd, req, cons, ret;
    logic [CW-1:0] count;
    logic          full, empty, timeout, busy;
    logic [C-1:0]  chan;
`ifdef BP_LCE_STALL_CTRL_STATS_EN
    logic [31:0]   events, busy_cyc;
`endif

    int n_vec = 0;
    int n_err = 0;

    int          run_len [C];
    int          latched;
    int          drain_left;
    int          m_credits;
    logic [31:0] m_events, m_busy_cycles;
    logic        exp_busy;

    always #5 clk = ~clk;

    bp_lce_stall_ctrl #(
        .channels_p(C), .timeout_max_limit_p(L), .hold_cycles_p(H),
        .credits_p(CP), .stat_width_p(32)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .mem_pkt_v_i(v), .mem_pkt_yumi_i(y),
        .cmd_ready_i(cmd), .req_ready_i(req),
        .credit_consume_i(cons), .credit_return_i(ret),
        .credit_count_o(count), .credits_full_o(full), .credits_empty_o(empty),
        .timeout_o(timeout), .timeout_chan_o(chan),
`ifdef BP_LCE_STALL_CTRL_STATS_EN
        .timeout_events_o(events), .busy_cycles_o(busy_cyc),
`endif
        .cache_req_busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int lowest_sat();
        for (int i = 0; i < C; i++)
            if (run_len[i] >= L) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < C; i++) run_len[i] = 0;
        latched       = -1;
        drain_left    = 0;
        m_credits     = 0;
        m_events      = 0;
        m_busy_cycles = 0;
    endtask

    // Mid-cycle: compare every output against the model's view of this cycle.
    task automatic eval();
        logic exp_to;
        logic [C-1:0] exp_chan;
        #4;
        exp_to   = (latched >= 0) || (lowest_sat() >= 0);
        exp_chan = (latched >= 0) ? C'(1 << latched) : '0;
        exp_busy = rst || (m_credits == CP) || exp_to || !cmd || !req;
        check("timeout", 32'(timeout), 32'(exp_to));
        check("chan", 32'(chan), 32'(exp_chan));
        check("busy", 32'(busy), 32'(exp_busy));
        check("count", 32'(count), 32'(m_credits));
        check("full", 32'(full), 32'(m_credits == CP));
        check("empty", 32'(empty), 32'(m_credits == 0));
`ifdef BP_LCE_STALL_CTRL_STATS_EN
        check("events", events, m_events);
        check("busy_cycles", busy_cyc, m_busy_cycles);
`endif
    endtask

    task automatic adv();
        logic [C-1:0] b;
        int low;
        @(posedge clk);
        b   = v & ~y;
        low = lowest_sat();
        if (rst) begin
            model_reset();
        end else begin
            if (latched < 0) begin
                if (low >= 0) begin
                    latched = low;
                    m_events++;
                end
            end else if (drain_left == 0) begin
                if (!b[latched]) begin
                    if (H == 0) latched = -1;
                    else drain_left = H;
                end
            end else begin
                if (low >= 0) begin
                    latched    = low;
                    drain_left = 0;
                end else if (drain_left == 1) begin
                    latched    = -1;
                    drain_left = 0;
                end else begin
                    drain_left--;
                end
            end
            if (exp_busy) m_busy_cycles++;
            for (int i = 0; i < C; i++)
                run_len[i] = b[i] ? ((run_len[i] < 1000) ? run_len[i] + 1 : 1000) : 0;
            if (cons && !ret && m_credits < CP) m_credits++;
            if (ret && !cons && m_credits > 0) m_credits--;
        end
        #1;
    endtask

    task automatic idle(input int n);
        v = '0; y = '0; cons = 1'b0; ret = 1'b0;
        for (int i = 0; i < n; i++) begin
            eval();
            adv();
        end
    endtask

    initial begin
        rst = 1'b1; v = '0; y = '0; cmd = 1'b1; req = 1'b1; cons = 1'b0; ret = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        eval();
        check("reset_busy", 32'(busy), 32'd1);
        adv();
        rst = 1'b0;
        eval();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_count", 32'(count), 32'd0);
        adv();
        idle(2);

        // Single channel starvation with hold.
        for (int c = 0; c < 12; c++) begin
            v = (c <= 6) ? 3'b010 : 3'b000;
            y = (c == 6) ? 3'b010 : 3'b000;
            eval();
            if (c == 3) check("t1_pre", 32'(timeout), 32'd0);
            if (c == 4) check("t1_rise", 32'(timeout), 32'd1);
            if (c == 5) check("t1_chan", 32'(chan), 32'b010);
            if (c == 8) check("t1_hold", 32'(busy), 32'd1);
            if (c == 9) begin
                check("t1_fall", 32'(busy), 32'd0);
                check("t1_chan0", 32'(chan), 32'd0);
            end
            adv();
        end

        // Simultaneous saturation, then re-latch from drain.
        for (int c = 0; c < 16; c++) begin
            v = (c <= 6) ? 3'b101 : ((c <= 9) ? 3'b100 : 3'b000);
            y = (c == 6) ? 3'b001 : ((c == 9) ? 3'b100 : 3'b000);
            eval();
            if (c == 5) check("t2_low", 32'(chan), 32'b001);
            if (c == 8) check("t2_relatch", 32'(chan), 32'b100);
            adv();
        end

        // Third independent starvation event.
        for (int c = 0; c < 11; c++) begin
            v = (c <= 5) ? 3'b001 : 3'b000;
            y = (c == 5) ? 3'b001 : 3'b000;
            eval();
            adv();
        end
`ifdef BP_LCE_STALL_CTRL_STATS_EN
        eval();
        check("t3_events", events, 32'd3);
        adv();
`endif

        // Credits with credits_p = 2.
        for (int c = 0; c < 6; c++) begin
            cons = (c <= 2);
            ret  = (c == 2) || (c == 3);
            eval();
            if (c == 2) begin
                check("cr_two", 32'(count), 32'd2);
                check("cr_full", 32'(full), 32'd1);
                check("cr_busy", 32'(busy), 32'd1);
            end
            if (c == 3) check("cr_both", 32'(count), 32'd2);
            if (c == 4) begin
                check("cr_one", 32'(count), 32'd1);
                check("cr_free", 32'(busy), 32'd0);
            end
            adv();
        end
        cons = 1'b0; ret = 1'b0;

        // Reset during e_force with one credit outstanding.
        for (int c = 0; c < 7; c++) begin
            v   = (c <= 5) ? 3'b010 : 3'b000;
            rst = (c == 5);
            eval();
            if (c == 5) check("rs_pre", 32'(timeout), 32'd1);
            if (c == 6) begin
                check("rs_count", 32'(count), 32'd0);
                check("rs_timeout", 32'(timeout), 32'd0);
                check("rs_chan", 32'(chan), 32'd0);
            end
            adv();
        end
        idle(3);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < C; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                y[i] = ($urandom_range(0, 3) == 0);
            end
            cmd  = ($urandom_range(0, 15) != 0);
            req  = ($urandom_range(0, 15) != 0);
            cons = ($urandom_range(0, 2) == 0);
            ret  = ($urandom_range(0, 2) == 0);
            if (cons && !ret && m_credits == CP) cons = 1'b0;
            if (ret && !cons && m_credits == 0) ret = 1'b0;
            eval();
            adv();
        end
        rst = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
